// File: rtl/uart_bcode_time_tx.sv
// rtl/uart_bcode_time_tx.sv - free-running B-code time-of-year clock serialised as an 8-byte UART frame once per second
// Optional feature macro: UART_BCODE_PARITY_EN (adds an even-parity bit per byte, 8E1 instead of 8N1)
module uart_bcode_time_tx #(
    parameter int          CLK_FREQ    = 50_000_000,
    parameter int          BAUD        = 9600,
    parameter int          TICK_CYCLES = CLK_FREQ,
    parameter logic [11:0] INIT_DAY    = 12'h001,
    parameter logic [7:0]  INIT_HOUR   = 8'h00,
    parameter logic [7:0]  INIT_MIN    = 8'h00,
    parameter logic [7:0]  INIT_SEC    = 8'h00
) (
    input  logic clk,
    input  logic rst_n,
    output logic tx
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    localparam logic [7:0] FRAME_HEAD = 8'hAA;
    localparam logic [7:0] FRAME_TAIL = 8'h55;

`ifdef UART_BCODE_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;
`endif

    // one-second time base
    logic [TW-1:0] tick_cnt;
    logic          tick;

    // live time of year, packed BCD
    logic [11:0] day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  sec;

    // frame snapshot, frozen for the whole frame
    logic [11:0] snap_day;
    logic [7:0]  snap_hour;
    logic [7:0]  snap_min;
    logic [7:0]  snap_sec;
    logic [7:0]  snap_csum;
    logic [7:0]  csum_now;

    // serialiser
    state_t        state;
    state_t        state_d;
    logic [BW-1:0] baud_cnt;
    logic [BW-1:0] baud_cnt_d;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_d;
    logic [2:0]    byte_idx;
    logic [2:0]    byte_idx_d;
    logic [7:0]    shreg;
    logic [7:0]    shreg_d;
    logic [7:0]    cur_byte;
    logic          baud_last;
    logic          tx_d;
`ifdef UART_BCODE_PARITY_EN
    logic          par_q;
    logic          par_d;
`endif

    // two-digit BCD increment; caller handles the wrap value
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        if (v[3:0] == 4'h9) begin
            return {v[7:4] + 4'h1, 4'h0};
        end
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

    // three-digit BCD day increment; caller handles 365 -> 001
    function automatic logic [11:0] day_inc(input logic [11:0] v);
        if (v[7:0] == 8'h99) begin
            return {v[11:8] + 4'h1, 8'h00};
        end
        return {v[11:8], bcd_inc2(v[7:0])};
    endfunction

    assign tick      = (tick_cnt == TICK_LAST);
    assign baud_last = (baud_cnt == BAUD_LAST);

    // free-running second counter, wraps on the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // time-of-year ripple carry sec -> min -> hour -> day on every tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day    <= INIT_DAY;
            hour   <= INIT_HOUR;
            minute <= INIT_MIN;
            sec    <= INIT_SEC;
        end else if (tick) begin
            if (sec != 8'h59) begin
                sec <= bcd_inc2(sec);
            end else begin
                sec <= 8'h00;
                if (minute != 8'h59) begin
                    minute <= bcd_inc2(minute);
                end else begin
                    minute <= 8'h00;
                    if (hour != 8'h23) begin
                        hour <= bcd_inc2(hour);
                    end else begin
                        hour <= 8'h00;
                        day  <= (day == 12'h365) ? 12'h001 : day_inc(day);
                    end
                end
            end
        end
    end

    // checksum over the five time bytes of the current time
    always_comb begin
        csum_now = {4'h0, day[11:8]} + day[7:0] + hour + minute + sec;
    end

    // latch the already-updated time during LOAD; held until the next LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_day  <= INIT_DAY;
            snap_hour <= INIT_HOUR;
            snap_min  <= INIT_MIN;
            snap_sec  <= INIT_SEC;
            snap_csum <= 8'h00;
        end else if (state == ST_LOAD) begin
            snap_day  <= day;
            snap_hour <= hour;
            snap_min  <= minute;
            snap_sec  <= sec;
            snap_csum <= csum_now;
        end
    end

    // frame byte selected by the byte index
    always_comb begin
        cur_byte = FRAME_TAIL;
        case (byte_idx)
            3'd0:    cur_byte = FRAME_HEAD;
            3'd1:    cur_byte = {4'h0, snap_day[11:8]};
            3'd2:    cur_byte = snap_day[7:0];
            3'd3:    cur_byte = snap_hour;
            3'd4:    cur_byte = snap_min;
            3'd5:    cur_byte = snap_sec;
            3'd6:    cur_byte = snap_csum;
            default: cur_byte = FRAME_TAIL;
        endcase
    end

    // serialiser next-state and next tx value (tx is registered from the next state)
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_cnt_d  = bit_cnt;
        byte_idx_d = byte_idx;
        shreg_d    = shreg;
`ifdef UART_BCODE_PARITY_EN
        par_d      = par_q;
`endif
        tx_d       = 1'b1;

        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                baud_cnt_d = '0;
                byte_idx_d = 3'd0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    shreg_d    = cur_byte;
`ifdef UART_BCODE_PARITY_EN
                    par_d      = ^cur_byte;
`endif
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    shreg_d    = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
`ifdef UART_BCODE_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + BW'(1);
                end
            end
`ifdef UART_BCODE_PARITY_EN
            ST_PARITY: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt + BW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_last) begin
                    baud_cnt_d = '0;
                    if (byte_idx == 3'd7) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx + 3'd1;
                        state_d    = ST_START;
                    end
                end else begin
                    baud_cnt_d = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
`ifdef UART_BCODE_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // serialiser registers; reset forces the line idle immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            byte_idx <= 3'd0;
            shreg    <= 8'h00;
`ifdef UART_BCODE_PARITY_EN
            par_q    <= 1'b0;
`endif
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_cnt  <= bit_cnt_d;
            byte_idx <= byte_idx_d;
            shreg    <= shreg_d;
`ifdef UART_BCODE_PARITY_EN
            par_q    <= par_d;
`endif
            tx       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_bcode_time_tx.sv
// tb/tb_uart_bcode_time_tx.sv - directed self-checking bench for uart_bcode_time_tx
module tb_uart_bcode_time_tx;

    localparam int CLK_FREQ  = 1000;
    localparam int BAUD      = 100;
    localparam int DIV       = 10;
    localparam int TICK      = 1000;
    localparam int TICK_FAST = 500;
`ifdef UART_BCODE_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic [4:0] rst_n = 5'b00000;
    wire  [4:0] tx_bus;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int r_main   = 0;
    int t_first  = 0;

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_bcode_time_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TICK_CYCLES(TICK)) u_main (
        .clk(clk), .rst_n(rst_n[0]), .tx(tx_bus[0]));

    uart_bcode_time_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TICK_CYCLES(TICK),
        .INIT_DAY(12'h365), .INIT_HOUR(8'h23), .INIT_MIN(8'h59), .INIT_SEC(8'h59)) u_roll (
        .clk(clk), .rst_n(rst_n[1]), .tx(tx_bus[1]));

    uart_bcode_time_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TICK_CYCLES(TICK),
        .INIT_DAY(12'h001), .INIT_HOUR(8'h00), .INIT_MIN(8'h59), .INIT_SEC(8'h59)) u_hcarry (
        .clk(clk), .rst_n(rst_n[2]), .tx(tx_bus[2]));

    uart_bcode_time_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TICK_CYCLES(TICK),
        .INIT_DAY(12'h099), .INIT_HOUR(8'h23), .INIT_MIN(8'h59), .INIT_SEC(8'h59)) u_dcarry (
        .clk(clk), .rst_n(rst_n[3]), .tx(tx_bus[3]));

    uart_bcode_time_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TICK_CYCLES(TICK_FAST)) u_fast (
        .clk(clk), .rst_n(rst_n[4]), .tx(tx_bus[4]));

    task automatic release_rst(input int inst, output int r);
        @(negedge clk);
        rst_n[inst] = 1'b1;
        r = cyc;
    endtask

    // UART monitor: finds a start bit, then samples every cycle of every bit
    task automatic recv_frame(input int inst, input int budget, output logic [63:0] data,
                              output int t0, output int errs);
        logic v;
        logic first;
        logic [7:0] b;
        data  = '0;
        t0    = -1;
        errs  = 0;
        first = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tx_bus[inst] === 1'b0) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) return;
        for (int i = 0; i < 8; i++) begin
            b = 8'h00;
            for (int j = 0; j < NBITS; j++) begin
                for (int c = 0; c < DIV; c++) begin
                    if (!(i == 0 && j == 0 && c == 0)) @(negedge clk);
                    v = tx_bus[inst];
                    if (c == 0) first = v;
                    else if (v !== first) errs++;
                end
                if (j == 0) begin
                    if (first !== 1'b0) errs++;
                end else if (j <= 8) begin
                    b[j-1] = first;
                end else if (j == NBITS - 1) begin
                    if (first !== 1'b1) errs++;
                end else begin
                    if (first !== ^b) errs++;
                end
            end
            data[63-8*i -: 8] = b;
        end
    endtask

    task automatic test_reset;
        int bad;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_bus !== 5'b11111) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_tx_high bad_samples=%0d required=0", bad);
        end
        release_rst(0, r_main);
        checks++;
        if (tx_bus[0] !== 1'b1) begin
            failures++;
            $display("FAIL release_tx_high got=%b exp=1", tx_bus[0]);
        end
        bad = 0;
        for (int k = 0; k < TICK; k++) begin
            @(negedge clk);
            if (tx_bus[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_before_tick low_samples=%0d required=0", bad);
        end
    endtask

    task automatic test_first_frame;
        logic [63:0] d;
        int t0, errs;
        recv_frame(0, 50, d, t0, errs);
        t_first = t0;
        checks++;
        if (t0 !== r_main + TICK + 1) begin
            failures++;
            $display("FAIL first_start_cycle got=%0d exp=%0d", t0, r_main + TICK + 1);
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL first_framing errors=%0d exp=0", errs);
        end
        checks++;
        if (d !== 64'hAA00010000010255) begin
            failures++;
            $display("FAIL first_data got=%h exp=%h", d, 64'hAA00010000010255);
        end
    endtask

    task automatic test_second_frame;
        logic [63:0] d;
        int t0, errs;
        @(negedge clk);
        checks++;
        if (tx_bus[0] !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_frame got=%b exp=1", tx_bus[0]);
        end
        recv_frame(0, TICK, d, t0, errs);
        checks++;
        if (t0 !== t_first + TICK) begin
            failures++;
            $display("FAIL second_spacing got=%0d exp=%0d", t0 - t_first, TICK);
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL second_framing errors=%0d exp=0", errs);
        end
        checks++;
        if (d !== 64'hAA00010000020355) begin
            failures++;
            $display("FAIL second_data got=%h exp=%h", d, 64'hAA00010000020355);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [63:0] d;
        int t0, errs, r, bad;
        bit found;
        found = 1'b0;
        for (int k = 0; k < TICK + 100; k++) begin
            @(negedge clk);
            if (tx_bus[0] === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!found || tx_bus[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_frame_low found=%0d tx=%b exp=0", found, tx_bus[0]);
        end
        rst_n[0] = 1'b0;
        #1;
        checks++;
        if (tx_bus[0] !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_tx got=%b exp=1", tx_bus[0]);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx_bus[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_hold_tx low_samples=%0d required=0", bad);
        end
        release_rst(0, r);
        recv_frame(0, TICK + 50, d, t0, errs);
        checks++;
        if (t0 !== r + TICK + 1) begin
            failures++;
            $display("FAIL rerelease_start got=%0d exp=%0d", t0, r + TICK + 1);
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL rerelease_framing errors=%0d exp=0", errs);
        end
        checks++;
        if (d !== 64'hAA00010000010255) begin
            failures++;
            $display("FAIL rerelease_data got=%h exp=%h", d, 64'hAA00010000010255);
        end
    endtask

    task automatic test_rollover;
        logic [63:0] d;
        int t0, errs, r;
        release_rst(1, r);
        recv_frame(1, TICK + 50, d, t0, errs);
        checks++;
        if (t0 !== r + TICK + 1) begin
            failures++;
            $display("FAIL rollover_start got=%0d exp=%0d", t0, r + TICK + 1);
        end
        checks++;
        if (errs !== 0 || d !== 64'hAA00010000000155) begin
            failures++;
            $display("FAIL rollover_data got=%h errors=%0d exp=%h", d, errs, 64'hAA00010000000155);
        end
    endtask

    task automatic test_carry;
        logic [63:0] d;
        int t0, errs, r;
        release_rst(2, r);
        recv_frame(2, TICK + 50, d, t0, errs);
        checks++;
        if (t0 !== r + TICK + 1) begin
            failures++;
            $display("FAIL hour_carry_start got=%0d exp=%0d", t0, r + TICK + 1);
        end
        checks++;
        if (errs !== 0 || d !== 64'hAA00010100000255) begin
            failures++;
            $display("FAIL hour_carry_data got=%h errors=%0d exp=%h", d, errs, 64'hAA00010100000255);
        end
        release_rst(3, r);
        recv_frame(3, TICK + 50, d, t0, errs);
        checks++;
        if (errs !== 0 || d !== 64'hAA01000000000155) begin
            failures++;
            $display("FAIL day_carry_data got=%h errors=%0d exp=%h", d, errs, 64'hAA01000000000155);
        end
    endtask

    task automatic test_inflight_tick;
        logic [63:0] d;
        int t0, errs, r;
        release_rst(4, r);
        recv_frame(4, TICK_FAST + 50, d, t0, errs);
        checks++;
        if (t0 !== r + TICK_FAST + 1) begin
            failures++;
            $display("FAIL fast_first_start got=%0d exp=%0d", t0, r + TICK_FAST + 1);
        end
        checks++;
        if (errs !== 0 || d !== 64'hAA00010000010255) begin
            failures++;
            $display("FAIL fast_first_data got=%h errors=%0d exp=%h", d, errs, 64'hAA00010000010255);
        end
        recv_frame(4, 2 * TICK_FAST, d, t0, errs);
        checks++;
        if (t0 !== r + 3 * TICK_FAST + 1) begin
            failures++;
            $display("FAIL fast_second_start got=%0d exp=%0d", t0, r + 3 * TICK_FAST + 1);
        end
        checks++;
        if (errs !== 0 || d !== 64'hAA00010000030455) begin
            failures++;
            $display("FAIL fast_second_data got=%h errors=%0d exp=%h", d, errs, 64'hAA00010000030455);
        end
    endtask

    initial begin
        test_reset;
        test_first_frame;
        test_second_frame;
        test_reset_mid_frame;
        test_rollover;
        test_carry;
        test_inflight_tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
